// File: rtl/pe_mac_tree.sv
// Streaming dot-product engine: N_IN signed-weight x unsigned-activation products per beat,
// reduced through a registered adder tree and accumulated per vector into a saturated result.
module pe_mac_tree #(
  parameter int N_IN  = 8,
  parameter int IN_W  = 2,
  parameter int W_W   = 16,
  parameter int ACC_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic [N_IN*IN_W-1:0]   in_data,
  input  logic [N_IN*W_W-1:0]    in_weight,
  output logic                   out_valid,
  output logic [ACC_W-1:0]       out_data,
  output logic                   out_sat
);

  localparam int LVL = $clog2(N_IN);
  localparam int PW  = W_W + IN_W + 1;
  localparam int TW  = PW + LVL;
  localparam int SW  = ((ACC_W > TW) ? ACC_W : TW) + 1;
  localparam int NV  = LVL + 2;

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0]     ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]     ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Handshake: no backpressure. A beat is taken on any edge with in_valid=1, en=1, clr=0;
  // out_valid is a one-en-cycle pulse that downstream must sample on en=1 cycles.

  logic [N_IN*IN_W-1:0] act_q, act_d;
  logic [N_IN*W_W-1:0]  wgt_q, wgt_d;
  logic [NV-1:0]        vld_q, vld_d, lst_q, lst_d;
  logic signed [PW-1:0] prod_q [N_IN];
  logic signed [PW-1:0] prod_d [N_IN];

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    flag_q, flag_d;
  logic                    out_valid_q, out_valid_d;
  logic [ACC_W-1:0]        out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  always_comb begin
    act_d = in_data;
    wgt_d = in_weight;
    vld_d = {vld_q[NV-2:0], in_valid};
    lst_d = {lst_q[NV-2:0], in_last};
    for (int i = 0; i < N_IN; i++) begin
      prod_d[i] = $signed({{(PW-W_W){wgt_q[i*W_W+W_W-1]}}, wgt_q[i*W_W +: W_W]})
                * $signed({{(PW-IN_W){1'b0}}, act_q[i*IN_W +: IN_W]});
    end
  end

  genvar k;
  generate
    for (k = 1; k <= LVL; k++) begin : g_lvl
      localparam int CNT = N_IN >> k;
      localparam int LW  = PW + k;
      logic signed [LW-1:0] sum_d [CNT];
      logic signed [LW-1:0] sum_q [CNT];

      if (k == 1) begin : g_first
        always_comb begin
          for (int j = 0; j < CNT; j++) begin
            sum_d[j] = {prod_q[2*j][PW-1], prod_q[2*j]}
                     + {prod_q[2*j+1][PW-1], prod_q[2*j+1]};
          end
        end
      end else begin : g_rest
        always_comb begin
          for (int j = 0; j < CNT; j++) begin
            sum_d[j] = {g_lvl[k-1].sum_q[2*j][LW-2], g_lvl[k-1].sum_q[2*j]}
                     + {g_lvl[k-1].sum_q[2*j+1][LW-2], g_lvl[k-1].sum_q[2*j+1]};
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < CNT; j++) sum_q[j] <= '0;
        end else if (en && !clr) begin
          for (int j = 0; j < CNT; j++) sum_q[j] <= sum_d[j];
        end
      end
    end
  endgenerate

  logic signed [TW-1:0] tree_sum;
  logic signed [SW-1:0] sum_full;
  logic                 sat_hi, sat_lo;
  logic [ACC_W-1:0]     sat_val;

  assign tree_sum = g_lvl[LVL].sum_q[0];

  always_comb begin
    sum_full = {{(SW-ACC_W){acc_q[ACC_W-1]}}, acc_q} + {{(SW-TW){tree_sum[TW-1]}}, tree_sum};
    sat_hi   = sum_full > SAT_MAX;
    sat_lo   = sum_full < SAT_MIN;
    sat_val  = sat_hi ? ACC_MAX : (sat_lo ? ACC_MIN : sum_full[ACC_W-1:0]);

    acc_d       = acc_q;
    flag_d      = flag_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (vld_q[NV-1]) begin
      if (lst_q[NV-1]) begin
        out_valid_d = 1'b1;
        out_data_d  = sat_val;
        out_sat_d   = flag_q | sat_hi | sat_lo;
        acc_d       = '0;
        flag_d      = 1'b0;
      end else begin
        acc_d  = sat_val;
        flag_d = flag_q | sat_hi | sat_lo;
      end
    end
  end

  // clr drops valid bits and accumulator state but leaves datapath registers and out_data alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q       <= '0;
      wgt_q       <= '0;
      vld_q       <= '0;
      lst_q       <= '0;
      for (int i = 0; i < N_IN; i++) prod_q[i] <= '0;
      acc_q       <= '0;
      flag_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (clr) begin
      vld_q       <= '0;
      acc_q       <= '0;
      flag_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
    end else if (en) begin
      act_q       <= act_d;
      wgt_q       <= wgt_d;
      vld_q       <= vld_d;
      lst_q       <= lst_d;
      for (int i = 0; i < N_IN; i++) prod_q[i] <= prod_d[i];
      acc_q       <= acc_d;
      flag_q      <= flag_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_pe_mac_tree.sv
// Directed bench for pe_mac_tree (N_IN=8, IN_W=2, W_W=16, ACC_W=16, latency 6 cycles).
module tb_pe_mac_tree;

  localparam int N_IN  = 8;
  localparam int IN_W  = 2;
  localparam int W_W   = 16;
  localparam int ACC_W = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic                  clr;
  logic                  in_valid;
  logic                  in_last;
  logic [N_IN*IN_W-1:0]  in_data;
  logic [N_IN*W_W-1:0]   in_weight;
  logic                  out_valid;
  logic [ACC_W-1:0]      out_data;
  logic                  out_sat;

  int n_cmp = 0;
  int n_err = 0;

  pe_mac_tree #(.N_IN(N_IN), .IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_weight (in_weight),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input logic [IN_W-1:0] act, input logic [W_W-1:0] w, input logic last);
    for (int i = 0; i < N_IN; i++) begin
      in_data[i*IN_W +: IN_W] = act;
      in_weight[i*W_W +: W_W] = w;
    end
    in_valid = 1'b1;
    in_last  = last;
  endtask

  task automatic set_ramp_beat();
    for (int i = 0; i < N_IN; i++) begin
      in_data[i*IN_W +: IN_W] = 2'd1;
      in_weight[i*W_W +: W_W] = 16'(i + 1);
    end
    in_valid = 1'b1;
    in_last  = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [ACC_W-1:0] d, input logic s);
    check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, "_data"},  {16'd0, out_data},  {16'd0, d});
    check({tag, "_sat"},   {31'd0, out_sat},   {31'd0, s});
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; clr = 1'b0;
    in_data = '0; in_weight = '0; in_valid = 1'b0; in_last = 1'b0;

    // Reset: asserted between edges, outputs must clear immediately.
    #2 rst = 1'b1;
    #1 check_out("reset", 1'b0, 16'h0000, 1'b0);
    step();
    step();
    rst = 1'b0;

    // Single beat, weights 1..8, act 1: 36 after six cycles, for one cycle only.
    set_ramp_beat();
    step();
    idle();
    for (int s = 2; s <= 5; s++) begin
      step();
      check("t1_early_valid", {31'd0, out_valid}, 32'd0);
    end
    step();
    check_out("t1_out", 1'b1, 16'd36, 1'b0);
    step();
    check("t1_pulse_end", {31'd0, out_valid}, 32'd0);

    // Three-beat vector, act 3 x weight 100 on 8 lanes = 2400 per beat, 7200 total.
    set_beat(2'd3, 16'd100, 1'b0);
    step();
    step();
    set_beat(2'd3, 16'd100, 1'b1);
    step();
    idle();
    for (int s = 2; s <= 5; s++) begin
      step();
      check("t2_no_partial_valid", {31'd0, out_valid}, 32'd0);
    end
    step();
    check_out("t2_out", 1'b1, 16'd7200, 1'b0);
    step();
    check("t2_pulse_end", {31'd0, out_valid}, 32'd0);

    // Back-to-back single-beat vectors: positive clip, negative clip, then clean 8.
    set_beat(2'd3, 16'h7FFF, 1'b1);
    step();
    set_beat(2'd3, 16'h8000, 1'b1);
    step();
    set_beat(2'd1, 16'd1, 1'b1);
    step();
    idle();
    for (int s = 4; s <= 5; s++) begin
      step();
      check("t3_early_valid", {31'd0, out_valid}, 32'd0);
    end
    step();
    check_out("t3_sat_pos", 1'b1, 16'h7FFF, 1'b1);
    step();
    check_out("t3_sat_neg", 1'b1, 16'h8000, 1'b1);
    step();
    check_out("t3_clean", 1'b1, 16'd8, 1'b0);
    step();
    check("t3_pulse_end", {31'd0, out_valid}, 32'd0);

    // Stall: three en=0 cycles after acceptance push the result to cycle 9.
    set_ramp_beat();
    step();
    idle();
    en = 1'b0;
    for (int s = 2; s <= 4; s++) begin
      step();
      check("t4_stall_valid", {31'd0, out_valid}, 32'd0);
    end
    en = 1'b1;
    for (int s = 5; s <= 8; s++) begin
      step();
      check("t4_early_valid", {31'd0, out_valid}, 32'd0);
    end
    step();
    check_out("t4_out", 1'b1, 16'd36, 1'b0);
    en = 1'b0;
    step();
    check_out("t4_hold1", 1'b1, 16'd36, 1'b0);
    step();
    check_out("t4_hold2", 1'b1, 16'd36, 1'b0);
    en = 1'b1;
    step();
    check("t4_pulse_end", {31'd0, out_valid}, 32'd0);

    // clr flushes two partial beats (160) and drops the last beat offered alongside it.
    set_beat(2'd1, 16'd10, 1'b0);
    step();
    step();
    clr = 1'b1;
    set_beat(2'd1, 16'd50, 1'b1);
    step();
    clr = 1'b0;
    set_beat(2'd1, 16'd1, 1'b1);
    step();
    idle();
    for (int s = 2; s <= 5; s++) begin
      step();
      check("t5_no_stale_valid", {31'd0, out_valid}, 32'd0);
    end
    step();
    check_out("t5_out", 1'b1, 16'd8, 1'b0);

    // Async reset with four beats in flight, then act 2 x weight -5 -> -80.
    set_beat(2'd1, 16'd1, 1'b0);
    step();
    step();
    step();
    set_beat(2'd1, 16'd1, 1'b1);
    step();
    idle();
    #2 rst = 1'b1;
    #1 check_out("t6_async_rst", 1'b0, 16'h0000, 1'b0);
    step();
    rst = 1'b0;
    set_beat(2'd2, 16'hFFFB, 1'b1);
    step();
    idle();
    for (int s = 2; s <= 5; s++) begin
      step();
      check("t6_no_inflight_valid", {31'd0, out_valid}, 32'd0);
    end
    step();
    check_out("t6_out", 1'b1, 16'hFFB0, 1'b0);
    step();
    check("t6_pulse_end", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pe_mac_tree.md
# pe_mac_tree

Parametrised pipelined dot-product engine for the VAE datapath: multiplies N_IN unsigned quantised activations by N_IN signed weights per beat, reduces them through a registered binary adder tree, and accumulates successive beats into one saturated result per vector. It is the scalable, streaming successor of the fixed 8-input PE. Vectors longer than N_IN are split into multiple beats, and the accumulator closes each vector on a `last` marker. It sits between the weight/activation fetch logic and the activation-function stage.

## Interface

- N_IN, 8, inputs per beat; power of two, ≥2
- IN_W, 2, activation width, unsigned integer
- W_W, 16, weight width, two's complement
- ACC_W, 16, accumulator/output width, two's complement
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  pipeline advance; 0 freezes every register
- clr  in  1  synchronous flush of pipeline and accumulator
- in_valid  in  1  beat present
- in_last  in  1  beat is final beat of vector (qualified by in_valid)
- in_data  in  N_IN*IN_W  activations, lane i at [i*IN_W +: IN_W]
- in_weight  in  N_IN*W_W  weights, lane i at [i*W_W +: W_W]
- out_valid  out  1  result present, one en-cycle per vector
- out_data  out  ACC_W  saturated vector sum
- out_sat  out  1  saturation occurred anywhere in this vector

## Operation

- Beat accepted when in_valid=1 and en=1 at a rising edge; in_valid with en=0 is ignored, not queued.
- Stage S0: register in_data, in_weight, valid, last.
- Stage S1: per-lane product = signed(weight) × unsigned(act), exact, width W_W+IN_W+1; registered.
- Stages T1..T(log2 N_IN): pairwise adds, lane 2j + 2j+1, one register level each; width grows 1 bit per level. No internal overflow.
- Stage A: acc_sum = acc + sign-extended tree sum, saturated to ACC_W range [-2^(ACC_W-1), 2^(ACC_W-1)-1]; saturation sets a sticky flag.
- Non-last valid beat at A: acc ← saturated sum, flag kept; out_valid=0.
- Last valid beat at A: out_data ← saturated sum, out_sat ← flag OR this beat's saturation, out_valid=1; acc ← 0, flag ← 0.
- Invalid slot at A: acc, flag unchanged; out_valid=0.
- Single-beat vectors (in_last on every beat) and back-to-back vectors at full rate are supported; no bubbles are needed between vectors.
- Valid/last bits travel alongside data in every stage; data registers of invalid slots may hold don't-care values.
- Priority per edge: rst > clr > en.
- clr=1 (ignores en): all valid bits ← 0, acc ← 0, flag ← 0, out_valid ← 0, out_sat ← 0. out_data holds its value. The beat presented in the same cycle is dropped.
- en=0: all registers, including out_valid/out_data/out_sat, hold. Downstream samples the output only on en=1 cycles.

## Timing

- Latency LAT = log2(N_IN)+3 cycles: a last beat presented in cycle 0 produces out_valid=1 in cycle LAT. For N_IN=8, LAT = 6.
- Each en=0 cycle inside that window extends the latency by one.
- Throughput: one beat per en-cycle.
- out_valid is high for exactly one en-cycle per vector.
- Reset values (asynchronous, immediate on rst=1): out_valid=0, out_data=0, out_sat=0, acc=0, flag=0, all pipeline valid bits 0, all data registers 0.
- Reset mid-vector discards all in-flight beats and any partial sum; no out_valid follows.
- Release of rst is synchronous to clk; the first beat can be accepted at the first edge after deassertion.

## Test plan

All scenarios use N_IN=8, IN_W=2, W_W=16, ACC_W=16.

- Single beat: act=1 on all lanes, weights 1..8, last=1 → out_valid in cycle 6, out_data=36, out_sat=0, for one cycle only.
- Multi-beat: 3 consecutive beats, act=3 and weight=100 on all lanes, last on the 3rd beat → one out_valid, out_data=7200, with no pulses for beats 1–2.
- Saturation: weight=0x7FFF, act=3, single beat → out_data=0x7FFF, out_sat=1. Weight=0x8000, act=3 → out_data=0x8000, out_sat=1. The next non-saturating vector → out_sat=0.
- Stall: same stimulus as single beat, with en=0 for 3 cycles after acceptance → out_valid in cycle 9, out_data=36, outputs frozen during the stall.
- clr: two non-last beats of act=1, weight=10 (sum 160), then clr, then a single beat of act=1, weight=1 → out_data=8, with no out_valid from the cleared beats.
- Async reset: assert rst asynchronously between edges while 4 beats are in flight → outputs 0 immediately. After release, a new single beat of act=2, weight=−5 → out_data=−80 (0xFFB0) at cycle 6.
